// File: rtl/bp_update_reporter.sv
// Converts committed conditional-branch outcomes into one predictor update per cycle via a
// small FIFO with bypass. Optional accuracy counters are built when BP_UPDATE_STATS_EN is defined.
module bp_update_reporter #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              cm_valid,
  output logic              cm_ready,
  input  logic [ADDR_W-1:0] cm_inst_addr,
  input  logic              cm_pred,
  input  logic              cm_jump,
  output logic              rob_bp_enable,
  output logic [ADDR_W-1:0] rob_bp_inst_addr,
  output logic              rob_bp_jump,
  output logic              rob_bp_correct,
  output logic [ADDR_W-1:0] stat_total,
  output logic [ADDR_W-1:0] stat_correct
);

  localparam logic [DEPTH_W:0]   FULL_CNT = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

  // Entry layout: {addr, jump, correct}
  logic [ADDR_W+1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH:0]     unused_pad;
  logic [DEPTH_W:0]   count, count_nxt;

  logic              empty, push, pop, wr_en, issue;
  logic              in_correct;
  logic [ADDR_W+1:0] in_entry, head_entry, iss_entry;

  assign unused_pad = '0;
  assign cm_ready   = (count != FULL_CNT);
  assign empty      = (count == '0);
  assign in_correct = (cm_pred == cm_jump);
  assign in_entry   = {cm_inst_addr, cm_jump, in_correct};
  assign head_entry = mem[rd_ptr];

  assign push  = cm_valid && cm_ready && rdy;
  assign pop   = rdy && !empty;
  // An empty FIFO hands the incoming entry straight to the output registers
  assign wr_en = push && !empty;
  assign issue = rdy && (!empty || push);

  always_comb begin
    iss_entry = empty ? in_entry : head_entry;
    count_nxt = count;
    if (wr_en && !pop)
      count_nxt = count + CNT_ONE;
    else if (!wr_en && pop)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      rob_bp_enable    <= 1'b0;
      rob_bp_inst_addr <= '0;
      rob_bp_jump      <= 1'b0;
      rob_bp_correct   <= 1'b0;
    end else if (rdy) begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count         <= count_nxt;
      rob_bp_enable <= issue;
      if (issue) begin
        rob_bp_inst_addr <= iss_entry[ADDR_W+1:2];
        rob_bp_jump      <= iss_entry[1];
        rob_bp_correct   <= iss_entry[0];
      end
    end
  end

`ifdef BP_UPDATE_STATS_EN
  logic [ADDR_W-1:0] total_q, correct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      correct_q <= '0;
    end else if (issue) begin
      total_q <= total_q + ADDR_W'(1);
      if (iss_entry[0])
        correct_q <= correct_q + ADDR_W'(1);
    end
  end

  assign stat_total   = total_q;
  assign stat_correct = correct_q;
`else
  assign stat_total   = '0;
  assign stat_correct = '0;
`endif

endmodule

// File: tb/tb_bp_update_reporter.sv
// Directed plus randomized bench for bp_update_reporter against a queue-based reference model.
module tb_bp_update_reporter;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n, rdy, cm_valid, cm_pred, cm_jump;
  logic              cm_ready, rob_bp_enable, rob_bp_jump, rob_bp_correct;
  logic [ADDR_W-1:0] cm_inst_addr, rob_bp_inst_addr, stat_total, stat_correct;

  bp_update_reporter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DEPTH_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_inst_addr(cm_inst_addr),
    .cm_pred(cm_pred), .cm_jump(cm_jump),
    .rob_bp_enable(rob_bp_enable), .rob_bp_inst_addr(rob_bp_inst_addr),
    .rob_bp_jump(rob_bp_jump), .rob_bp_correct(rob_bp_correct),
    .stat_total(stat_total), .stat_correct(stat_correct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic              j;
    logic              c;
  } ent_t;

  ent_t              q[$];
  logic              exp_en, exp_j, exp_c;
  logic [ADDR_W-1:0] exp_a, exp_tot, exp_cor;
  int                vectors = 0;
  int                miscompares = 0;
  int                pulses;

  task automatic chk(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_en = 0; exp_a = '0; exp_j = 0; exp_c = 0; exp_tot = '0; exp_cor = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".enable"},  ADDR_W'(rob_bp_enable),  ADDR_W'(exp_en));
    chk({tag, ".addr"},    rob_bp_inst_addr,        exp_a);
    chk({tag, ".jump"},    ADDR_W'(rob_bp_jump),    ADDR_W'(exp_j));
    chk({tag, ".correct"}, ADDR_W'(rob_bp_correct), ADDR_W'(exp_c));
`ifdef BP_UPDATE_STATS_EN
    chk({tag, ".stat_total"},   stat_total,   exp_tot);
    chk({tag, ".stat_correct"}, stat_correct, exp_cor);
`else
    chk({tag, ".stat_total"},   stat_total,   '0);
    chk({tag, ".stat_correct"}, stat_correct, '0);
`endif
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input string tag, input logic v, input logic [ADDR_W-1:0] a,
                       input logic p, input logic j, input logic r);
    logic acc;
    ent_t e;
    cm_valid = v; cm_inst_addr = a; cm_pred = p; cm_jump = j; rdy = r;
    #1;
    chk({tag, ".cm_ready"}, ADDR_W'(cm_ready), ADDR_W'(q.size() < DEPTH));
    acc = r && v && (q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (r) begin
      if (acc) begin
        e.a = a; e.j = j; e.c = (p == j);
        q.push_back(e);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_en = 1; exp_a = e.a; exp_j = e.j; exp_c = e.c;
        exp_tot = exp_tot + 1;
        if (e.c) exp_cor = exp_cor + 1;
      end else begin
        exp_en = 0;
      end
    end
    check_outputs(tag);
    if (rob_bp_enable && r) pulses++;
    @(negedge clk);
  endtask

  task automatic mid_reset(input string tag);
    #2;
    rst_n = 0;
    #1;
    model_clear();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1;
    cm_valid = 0;
    #1;
    chk({tag, ".ready_after"}, ADDR_W'(cm_ready), ADDR_W'(1));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; rdy = 1; cm_valid = 0; cm_inst_addr = '0; cm_pred = 0; cm_jump = 0;
    model_clear();
    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Single correct update, then idle
    cycle("single.push", 1, 32'h1000, 1, 1, 1);
    chk("single.en_const",   ADDR_W'(rob_bp_enable), ADDR_W'(1));
    chk("single.addr_const", rob_bp_inst_addr, 32'h1000);
    chk("single.corr_const", ADDR_W'(rob_bp_correct), ADDR_W'(1));
    cycle("single.idle", 0, '0, 0, 0, 1);
    chk("single.en_drop", ADDR_W'(rob_bp_enable), ADDR_W'(0));

    // Mispredict
    cycle("mispred", 1, 32'h2004, 1, 0, 1);
    chk("mispred.corr_const", ADDR_W'(rob_bp_correct), ADDR_W'(0));
    cycle("mispred.idle", 0, '0, 0, 0, 1);

    // Five back-to-back pushes
    pulses = 0;
    for (int i = 0; i < 5; i++)
      cycle("fill", 1, 32'h3000 + 32'(i * 4), i[0], 1, 1);
    cycle("fill.idle", 0, '0, 0, 0, 1);
    chk("fill.pulses", ADDR_W'(pulses), ADDR_W'(5));

    // rdy gating: outputs frozen, push ignored
    cycle("gate.push", 1, 32'h4000, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cycle("gate.frozen", 1, 32'h4444, 1, 1, 0);
    cycle("gate.resume", 1, 32'h4008, 0, 1, 1);
    chk("gate.addr_const", rob_bp_inst_addr, 32'h4008);
    cycle("gate.idle", 0, '0, 0, 0, 1);

    // Reset in the middle of traffic
    cycle("pre_rst", 1, 32'h5000, 1, 1, 1);
    cm_valid = 1;
    mid_reset("midreset");

    // Ten updates, seven correct
    for (int i = 0; i < 10; i++)
      cycle("stats", 1, 32'h6000 + 32'(i * 4), 1, (i < 7), 1);
    cycle("stats.idle", 0, '0, 0, 0, 1);
`ifdef BP_UPDATE_STATS_EN
    chk("stats.total_const",   stat_total,   32'd10);
    chk("stats.correct_const", stat_correct, 32'd7);
`else
    chk("stats.total_off",   stat_total,   32'd0);
    chk("stats.correct_off", stat_correct, 32'd0);
`endif

    // Randomized traffic with rdy stalls
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 2) != 0), $urandom, $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 4) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
